// File: rtl/fetch_ctrl_fifo.sv
// Entry-width constant for the prefetch buffer; the buffer logic is in fetch_fifo.sv.
package fetch_ctrl_fifo_pkg;
  localparam int FIFO_ENTRY_W = 64;
endpackage

// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller: FSM encoding and
// default geometry constants.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam int MEM_WORDS_DEFAULT = 1024;
  localparam int RESET_PC_DEFAULT  = 0;

  // Width of one prefetch entry: {instr[31:0], pc[31:0]}.
  localparam int ENTRY_W = 64;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO holding {instr, pc} entries.
// Handshake: an entry is written when push=1 and there is room (or a pop
// frees a slot in the same cycle); the head is removed when pop=1 and the
// FIFO is not empty. flush empties the FIFO and overrides push and pop.
module fetch_fifo
  import fetch_ctrl_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  logic [ENTRY_W-1:0] wdata,
  output logic [ENTRY_W-1:0] head,
  output logic [CW-1:0]      count,
  output logic               empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic               full;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Storage, pointers and occupancy; storage is cleared on reset so the
  // head reads as zero until the first push.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: walks a PC through instruction memory,
// prefetches words into a small FIFO and presents them to the consumer.
// Handshake: the consumer takes the head on a cycle where inst_valid=1 and
// inst_ready=1; inst_out/inst_pc hold steady while inst_valid=1 and
// inst_ready=0. redirect_valid overrides both push and pop on its edge.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int MEM_WORDS  = MEM_WORDS_DEFAULT,
  parameter int RESET_PC   = RESET_PC_DEFAULT,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  output logic        busy,
  output state_t      state
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [AW-1:0] RESET_PC_W = AW'(RESET_PC);
  localparam logic [AW-1:0] LAST_PC    = AW'(MEM_WORDS - 1);
  localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);

  state_t             next_state;
  logic [AW-1:0]      pc;
  logic [AW-1:0]      pc_next;
  logic [CW-1:0]      count;
  logic               empty;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] head;
  logic               unused_redirect_hi;

  // Only the low address bits of a redirect target are meaningful.
  assign unused_redirect_hi = ^redirect_pc[31:AW];

  assign imem_addr  = {{(32 - AW){1'b0}}, pc};
  assign inst_valid = !empty;
  assign inst_out   = head[63:32];
  assign inst_pc    = head[31:0];

  // Wrap explicitly so non-power-of-two depths still stay in range.
  assign pc_next = (pc == LAST_PC) ? '0 : pc + 1'b1;

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state plus push/pop decisions; a redirect wins over everything.
  // The FLUSH cycle itself pushes the first redirected word when enabled,
  // so the new stream appears right after FLUSH is left.
  always_comb begin
    next_state = state;
    busy       = (state != IDLE);
    push       = 1'b0;
    pop        = 1'b0;
    if (redirect_valid) begin
      next_state = FLUSH;
    end else begin
      pop = inst_valid && inst_ready;
      case (state)
        IDLE:    next_state = enable ? RUN : IDLE;
        RUN:     next_state = enable ? RUN : IDLE;
        FLUSH:   next_state = enable ? RUN : IDLE;
        default: next_state = IDLE;
      endcase
      if (enable && (state != IDLE) &&
          ((count < DEPTH_C) || (inst_valid && inst_ready))) begin
        push = 1'b1;
      end
    end
  end

  // Program counter: loaded by redirect, advanced by each push.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc <= RESET_PC_W;
    end else if (redirect_valid) begin
      pc <= redirect_pc[AW-1:0];
    end else if (push) begin
      pc <= pc_next;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .flush   (redirect_valid),
    .wdata   ({imem_data, imem_addr}),
    .head    (head),
    .count   (count),
    .empty   (empty)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a combinational instruction memory model.
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  logic        clock;
  logic        reset_n;
  logic        enable;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        busy;
  state_t      state;
  logic [31:0] mem_xor;

  int checks = 0;
  int errors = 0;

  fetch_ctrl #(
    .MEM_WORDS  (1024),
    .RESET_PC   (0),
    .FIFO_DEPTH (2)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .enable         (enable),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_out       (inst_out),
    .inst_pc        (inst_pc),
    .busy           (busy),
    .state          (state)
  );

  // Memory word k holds k, optionally scrambled so instr and pc differ.
  assign imem_data = imem_addr ^ mem_xor;

  // Clock generation.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Watchdog.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n        = 1'b0;
    enable         = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    mem_xor = 32'h0;
    reset_n = 1'b0;
    enable = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    #3;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", inst_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    checks++; if (inst_out !== 32'h0) begin errors++; $display("FAIL reset_out: got %0h expected 0", inst_out); end
    checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %0h expected 0", inst_pc); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %0h expected 0", imem_addr); end
    checks++; if (state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", state, IDLE); end
    do_reset();
  endtask

  task automatic test_stream();
    mem_xor = 32'h0;
    do_reset();
    enable = 1'b1; inst_ready = 1'b1;
    step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stream_busy: got %0b expected 1", busy); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL stream_first_valid: got %0b expected 0", inst_valid); end
    for (int k = 0; k < 6; k++) begin
      step();
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'(k) || inst_out !== 32'(k)) begin
        errors++;
        $display("FAIL stream_seq%0d: got v=%0b pc=%0h out=%0h expected v=1 pc=%0h out=%0h",
                 k, inst_valid, inst_pc, inst_out, k, k);
      end
    end
  endtask

  task automatic test_backpressure();
    mem_xor = 32'hA5A5_0000;
    do_reset();
    enable = 1'b1; inst_ready = 1'b0;
    for (int c = 0; c < 5; c++) step();
    checks++; if (imem_addr !== 32'd2) begin errors++; $display("FAIL bp_addr: got %0h expected 2", imem_addr); end
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'd0) begin errors++; $display("FAIL bp_head: got v=%0b pc=%0h expected v=1 pc=0", inst_valid, inst_pc); end
    checks++; if (inst_out !== 32'hA5A5_0000) begin errors++; $display("FAIL bp_out: got %0h expected a5a50000", inst_out); end
    inst_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      step();
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'(k) || inst_out !== (32'(k) ^ 32'hA5A5_0000)) begin
        errors++;
        $display("FAIL bp_resume%0d: got v=%0b pc=%0h out=%0h expected pc=%0h", k, inst_valid, inst_pc, inst_out, k);
      end
    end
  endtask

  task automatic test_redirect();
    mem_xor = 32'h1234_0000;
    do_reset();
    enable = 1'b1; inst_ready = 1'b1;
    for (int c = 0; c < 5; c++) step();
    inst_ready = 1'b0;
    step();
    checks++; if (inst_pc !== 32'd3 || imem_addr !== 32'd5) begin errors++; $display("FAIL redir_pre: got pc=%0h addr=%0h expected pc=3 addr=5", inst_pc, imem_addr); end
    redirect_valid = 1'b1; redirect_pc = 32'h0000_7C10;
    step();
    redirect_valid = 1'b0; inst_ready = 1'b1;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL redir_flush_valid: got %0b expected 0", inst_valid); end
    checks++; if (state !== FLUSH || busy !== 1'b1) begin errors++; $display("FAIL redir_flush_state: got %0d busy=%0b expected %0d busy=1", state, busy, FLUSH); end
    checks++; if (imem_addr !== 32'h10) begin errors++; $display("FAIL redir_addr: got %0h expected 10", imem_addr); end
    step();
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h10 || inst_out !== 32'h1234_0010) begin errors++; $display("FAIL redir_first: got v=%0b pc=%0h out=%0h expected v=1 pc=10 out=12340010", inst_valid, inst_pc, inst_out); end
    step();
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h11) begin errors++; $display("FAIL redir_second: got v=%0b pc=%0h expected pc=11", inst_valid, inst_pc); end
  endtask

  task automatic test_wrap();
    mem_xor = 32'h0;
    do_reset();
    enable = 1'b1; inst_ready = 1'b1;
    step(); step();
    redirect_valid = 1'b1; redirect_pc = 32'd1022;
    step();
    redirect_valid = 1'b0;
    checks++; if (imem_addr !== 32'd1022) begin errors++; $display("FAIL wrap_addr: got %0h expected 3fe", imem_addr); end
    step();
    checks++; if (inst_pc !== 32'd1022) begin errors++; $display("FAIL wrap_1022: got %0h expected 3fe", inst_pc); end
    step();
    checks++; if (inst_pc !== 32'd1023 || inst_out !== 32'd1023) begin errors++; $display("FAIL wrap_1023: got pc=%0h out=%0h expected 3ff", inst_pc, inst_out); end
    step();
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'd0 || inst_out !== 32'd0) begin errors++; $display("FAIL wrap_zero: got v=%0b pc=%0h out=%0h expected v=1 pc=0 out=0", inst_valid, inst_pc, inst_out); end
    step();
    checks++; if (inst_pc !== 32'd1) begin errors++; $display("FAIL wrap_one: got %0h expected 1", inst_pc); end
  endtask

  task automatic test_async_reset();
    mem_xor = 32'h0F0F_0000;
    do_reset();
    enable = 1'b1; inst_ready = 1'b0;
    for (int c = 0; c < 4; c++) step();
    checks++; if (inst_valid !== 1'b1 || imem_addr !== 32'd2) begin errors++; $display("FAIL arst_full: got v=%0b addr=%0h expected v=1 addr=2", inst_valid, imem_addr); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (inst_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL arst_clear: got v=%0b busy=%0b expected 0 0", inst_valid, busy); end
    checks++; if (inst_out !== 32'h0 || inst_pc !== 32'h0 || imem_addr !== 32'h0) begin errors++; $display("FAIL arst_data: got out=%0h pc=%0h addr=%0h expected 0", inst_out, inst_pc, imem_addr); end
    inst_ready = 1'b1;
    #2;
    reset_n = 1'b1;
    step();
    checks++; if (state !== RUN || inst_valid !== 1'b0) begin errors++; $display("FAIL arst_run: got state=%0d v=%0b expected %0d v=0", state, inst_valid, RUN); end
    step();
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'd0 || inst_out !== 32'h0F0F_0000) begin errors++; $display("FAIL arst_restart: got v=%0b pc=%0h out=%0h expected pc=0", inst_valid, inst_pc, inst_out); end
    step();
    checks++; if (inst_pc !== 32'd1) begin errors++; $display("FAIL arst_next: got %0h expected 1", inst_pc); end
  endtask

  task automatic test_enable_drop();
    mem_xor = 32'h0;
    do_reset();
    enable = 1'b1; inst_ready = 1'b0;
    step(); step(); step();
    enable = 1'b0;
    step();
    checks++; if (state !== IDLE || busy !== 1'b0) begin errors++; $display("FAIL en_idle: got state=%0d busy=%0b expected %0d 0", state, busy, IDLE); end
    checks++; if (imem_addr !== 32'd2) begin errors++; $display("FAIL en_nopush: got addr=%0h expected 2", imem_addr); end
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'd0) begin errors++; $display("FAIL en_head0: got v=%0b pc=%0h expected v=1 pc=0", inst_valid, inst_pc); end
    inst_ready = 1'b1;
    step();
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'd1) begin errors++; $display("FAIL en_head1: got v=%0b pc=%0h expected v=1 pc=1", inst_valid, inst_pc); end
    step();
    checks++; if (inst_valid !== 1'b0 || imem_addr !== 32'd2) begin errors++; $display("FAIL en_drained: got v=%0b addr=%0h expected v=0 addr=2", inst_valid, imem_addr); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_async_reset();
    test_enable_drop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter MEM_WORDS, default 1024: instruction memory depth in 32-bit words; PC wraps modulo this value.
REQ-002 Parameter RESET_PC, default 0: word address fetched first after reset.
REQ-003 Parameter FIFO_DEPTH, default 2: prefetch buffer entries; a power of two, at least 2.
REQ-004 clock  in  1  single clock; all state updates on the rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 enable  in  1  1 = fetching permitted; 0 = fetching paused.
REQ-007 imem_addr  out  32  word address driven to instruction memory; the memory returns data combinationally.
REQ-008 imem_data  in  32  instruction word at imem_addr, valid in the same cycle.
REQ-009 redirect_valid  in  1  one-cycle request to change the fetch stream.
REQ-010 redirect_pc  in  32  new word address; only bits [log2(MEM_WORDS)-1:0] are used.
REQ-011 inst_valid  out  1  FIFO head holds a valid instruction.
REQ-012 inst_ready  in  1  consumer accepts the head this cycle.
REQ-013 inst_out  out  32  instruction word at the FIFO head.
REQ-014 inst_pc  out  32  word address of inst_out, zero-extended.
REQ-015 busy  out  1  high when the FSM is in RUN or FLUSH.

Function
REQ-016 The FSM SHALL have three states: IDLE, RUN and FLUSH.
  - IDLE -> RUN when enable=1.
  - RUN -> IDLE when enable=0.
  - Any state -> FLUSH on redirect_valid=1.
  - FLUSH -> RUN after exactly one cycle if enable=1, otherwise FLUSH -> IDLE.
REQ-017 imem_addr SHALL equal the internal PC register, zero-extended, at all times.
REQ-018 Push: in RUN, without redirect_valid, when (count < FIFO_DEPTH) or (inst_valid and inst_ready), the block SHALL write {imem_data, PC} into the FIFO and advance PC to (PC+1) mod MEM_WORDS.
REQ-019 Pop: when inst_valid and inst_ready are both 1, the head SHALL be removed; a pop and a push in the same cycle SHALL both occur and leave count unchanged.
REQ-020 Latency: an instruction is pushed at edge N and SHALL appear with inst_valid=1 after edge N. Entering RUN at edge N gives the first inst_valid after edge N+1.
REQ-021 Redirect:
  - redirect_valid SHALL take priority over push and pop.
  - On that edge: FIFO emptied (count=0), PC loaded with the masked redirect_pc, FSM enters FLUSH.
  - No push occurs in FLUSH.
  - The first redirected instruction is pushed on the edge that leaves FLUSH (when enable=1).
REQ-022 inst_ready while inst_valid=0 SHALL have no effect.
REQ-023 The FIFO SHALL never overflow or underflow; count stays in 0..FIFO_DEPTH.
REQ-024 enable=0 SHALL stop pushes only; queued entries remain and pops continue.
REQ-025 Head outputs (inst_out, inst_pc) SHALL stay stable while inst_valid=1 and inst_ready=0.

Reset
REQ-026 While reset_n=0, the block SHALL immediately force:
  - PC=RESET_PC, FIFO count=0, read/write pointers=0, FSM=IDLE;
  - inst_valid=0, busy=0, inst_out=0, inst_pc=0, imem_addr=RESET_PC.
REQ-027 Reset asserted mid-operation SHALL discard all queued entries; after release, fetching restarts at RESET_PC.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding (IDLE, RUN, FLUSH) and the default MEM_WORDS and RESET_PC constants.
REQ-029 The prefetch buffer SHALL be one sub-module, fetch_fifo: synchronous FIFO, 64-bit entries {instr, pc}, FIFO_DEPTH entries, with push, pop, flush, count and head outputs.

Verification
REQ-030 Reset, then enable=1, inst_ready=1 with memory word k = k: first inst_valid one edge after entering RUN with inst_pc=0, inst_out=0; then one instruction per cycle, pc 1, 2, 3...
REQ-031 inst_ready=0 for 5 cycles from RUN: count stops at 2, imem_addr holds at 2, head stays pc=0; raising inst_ready resumes in order 0, 1, 2 with no gap.
REQ-032 Redirect to 0x10 while the FIFO holds pc 3 and 4: next cycle inst_valid=0 (FLUSH); the following edge pushes pc=0x10; pc 3 and 4 never delivered.
REQ-033 MEM_WORDS=1024 with PC reaching 1023: the next pushes deliver pc=1023 then pc=0.
REQ-034 reset_n pulsed low asynchronously mid-stream with a full FIFO: outputs clear before the next clock edge; after release the stream restarts at RESET_PC.
REQ-035 enable dropped with 2 entries queued: both are delivered, no new push occurs, FSM=IDLE, busy=0.
